// File: rtl/bit_count_unit_pkg.sv
// Shared mode encodings and decode helpers for the EX-stage bit-count unit.
package bit_count_unit_pkg;

  localparam int BCU_MODE_W = 3;

  typedef logic [BCU_MODE_W-1:0] bcu_mode_bus_t;

  typedef enum logic [BCU_MODE_W-1:0] {
    BCU_MODE_CLZ    = 3'd0,
    BCU_MODE_CLO    = 3'd1,
    BCU_MODE_CTZ    = 3'd2,
    BCU_MODE_CTO    = 3'd3,
    BCU_MODE_POPCNT = 3'd4
  } bcu_mode_e;

  localparam bcu_mode_bus_t BCU_MODE_RSVD = 3'd7;

  // funct2 codes issued by the decoder; new codes get mapped here only.
  localparam logic [1:0] FUNCT2_CLZ = 2'b00;
  localparam logic [1:0] FUNCT2_CLO = 2'b01;

  function automatic bcu_mode_bus_t bcu_decode_funct2(input logic [1:0] funct2);
    case (funct2)
      FUNCT2_CLZ: return BCU_MODE_CLZ;
      FUNCT2_CLO: return BCU_MODE_CLO;
      default:    return BCU_MODE_RSVD;
    endcase
  endfunction

  function automatic logic bcu_mode_inverts(input bcu_mode_bus_t m);
    return (m == BCU_MODE_CLO) || (m == BCU_MODE_CTO);
  endfunction

  function automatic logic bcu_mode_reverses(input bcu_mode_bus_t m);
    return (m == BCU_MODE_CTZ) || (m == BCU_MODE_CTO);
  endfunction

  // CLZ/CLO/CTZ/CTO all reduce to a leading-zero count after normalisation.
  function automatic logic bcu_mode_counts_lead(input bcu_mode_bus_t m);
    return (m == BCU_MODE_CLZ) || (m == BCU_MODE_CLO) ||
           (m == BCU_MODE_CTZ) || (m == BCU_MODE_CTO);
  endfunction

endpackage

// File: rtl/bit_count_group.sv
// Per-group counters: all-zero flag and leading zeros on the normalised
// slice, population count on the raw slice.
module bit_count_group #(
  parameter int GROUP_W = 8
) (
  input  logic [GROUP_W-1:0]       v_i,
  input  logic [GROUP_W-1:0]       raw_i,
  output logic                     gz_o,
  output logic [$clog2(GROUP_W):0] glz_o,
  output logic [$clog2(GROUP_W):0] gpop_o
);

  localparam int CW = $clog2(GROUP_W) + 1;

  assign gz_o = ~|v_i;

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    glz_o = CW'(GROUP_W);
    for (int i = 0; i < GROUP_W; i++) begin
      if (v_i[i]) begin
        glz_o = CW'(GROUP_W - 1 - i);
      end
    end
  end

  always_comb begin
    gpop_o = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      gpop_o = gpop_o + CW'(raw_i[i]);
    end
  end

endmodule

// File: rtl/bit_count_unit.sv
// Two-stage CLZ/CLO/CTZ/CTO/POPCNT unit with valid/ready on both sides,
// a pass-through tag and a pipeline flush.
module bit_count_unit
  import bit_count_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int GROUP_W = 8,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_operand,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int G  = DATA_W / GROUP_W;
  localparam int CW = $clog2(GROUP_W) + 1;
  localparam int RW = $clog2(DATA_W) + 1;

  logic                    adv1;
  logic                    adv2;
  logic [DATA_W-1:0]       op_inv;
  logic [DATA_W-1:0]       op_rev;
  logic [DATA_W-1:0]       v;
  logic [G-1:0]            gz;
  logic [G-1:0][CW-1:0]    glz;
  logic [G-1:0][CW-1:0]    gpop;

  logic                    s1_valid_q;
  bcu_mode_bus_t           s1_mode_q;
  logic [TAG_W-1:0]        s1_tag_q;
  logic [G-1:0]            s1_gz_q;
  logic [G-1:0][CW-1:0]    s1_glz_q;
  logic [G-1:0][CW-1:0]    s1_gpop_q;

  logic                    s2_valid_q;
  logic [RW-1:0]           s2_result_q;
  logic [TAG_W-1:0]        s2_tag_q;

  logic [RW-1:0]           pop_sum;
  logic [RW-1:0]           lead_cnt;
  logic [RW-1:0]           s2_result_d;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // Every counting mode is turned into a leading-zero search on v.
  assign op_inv = bcu_mode_inverts(in_mode) ? ~in_operand : in_operand;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign op_rev[gi] = op_inv[DATA_W-1-gi];
    end
  endgenerate

  assign v = bcu_mode_reverses(in_mode) ? op_rev : op_inv;

  // Group 0 is the most significant slice of v.
  generate
    for (genvar gi = 0; gi < G; gi++) begin : g_grp
      bit_count_group #(
        .GROUP_W (GROUP_W)
      ) u_grp (
        .v_i    (v[DATA_W-1-gi*GROUP_W -: GROUP_W]),
        .raw_i  (in_operand[DATA_W-1-gi*GROUP_W -: GROUP_W]),
        .gz_o   (gz[gi]),
        .glz_o  (glz[gi]),
        .gpop_o (gpop[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      s1_tag_q   <= '0;
      s1_gz_q    <= '0;
      s1_glz_q   <= '0;
      s1_gpop_q  <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= in_mode;
        s1_tag_q  <= in_tag;
        s1_gz_q   <= gz;
        s1_glz_q  <= glz;
        s1_gpop_q <= gpop;
      end
    end
  end

  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < G; i++) begin
      pop_sum = pop_sum + RW'(s1_gpop_q[i]);
    end
  end

  // Descending scan so the lowest-index non-zero group wins.
  always_comb begin
    lead_cnt = RW'(DATA_W);
    for (int i = G - 1; i >= 0; i--) begin
      if (!s1_gz_q[i]) begin
        lead_cnt = RW'(i * GROUP_W) + RW'(s1_glz_q[i]);
      end
    end
  end

  always_comb begin
    s2_result_d = '0;
    if (s1_mode_q == BCU_MODE_POPCNT) begin
      s2_result_d = pop_sum;
    end else if (bcu_mode_counts_lead(s1_mode_q)) begin
      s2_result_d = lead_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= s2_result_d;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = DATA_W'(s2_result_q);
  assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_bit_count_unit.sv
// Scoreboard bench for bit_count_unit: 32/8 and 64/16 instances.
module tb_bit_count_unit;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        out_ready;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_operand;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [2:0]  w_in_mode;
  logic [63:0] w_in_operand;
  logic [4:0]  w_in_tag;
  logic        w_out_valid;
  logic [63:0] w_out_result;
  logic [4:0]  w_out_tag;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_count_unit #(.DATA_W(32), .GROUP_W(8), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_operand(in_operand), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  bit_count_unit #(.DATA_W(64), .GROUP_W(16), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
    .in_operand(w_in_operand), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_result(w_out_result), .out_tag(w_out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Front of the queue is always what s2 must hold; pop on transfer.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL unexpected32 actual tag=%0d result=%0d required none", out_tag, out_result);
      end else begin
        if (out_result !== q32[0].res[31:0] || out_tag !== q32[0].tag) begin
          errors++;
          $display("FAIL result32 actual tag=%0d result=%0d required tag=%0d result=%0d",
                   out_tag, out_result, q32[0].tag, q32[0].res[31:0]);
        end
        if (out_ready) begin
          if (q32[0].lat) begin
            checks++;
            if (cyc - q32[0].acc != 2) begin
              errors++;
              $display("FAIL latency32 actual=%0d required=2", cyc - q32[0].acc);
            end
          end
          $display("tx32 tag=%0d result=%0d", out_tag, out_result);
          void'(q32.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && w_out_valid) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL unexpected64 actual tag=%0d result=%0d required none", w_out_tag, w_out_result);
      end else begin
        if (w_out_result !== q64[0].res || w_out_tag !== q64[0].tag) begin
          errors++;
          $display("FAIL result64 actual tag=%0d result=%0d required tag=%0d result=%0d",
                   w_out_tag, w_out_result, q64[0].tag, q64[0].res);
        end
        if (out_ready) begin
          $display("tx64 tag=%0d result=%0d", w_out_tag, w_out_result);
          void'(q64.pop_front());
        end
      end
    end
  end

  task automatic send(input bit wide, input logic [2:0] mode, input logic [63:0] op,
                      input logic [4:0] tag, input logic [63:0] res, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    if (wide) begin
      w_in_valid = 1'b1; w_in_mode = mode; w_in_operand = op; w_in_tag = tag;
    end else begin
      in_valid = 1'b1; in_mode = mode; in_operand = op[31:0]; in_tag = tag;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((wide ? w_in_ready : in_ready) && !flush && rst) begin
        e.res = res; e.tag = tag; e.acc = cyc; e.lat = lat;
        if (wide) q64.push_back(e);
        else q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    chk("accept_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (q32.size() != 0 || q64.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_mode = '0; in_operand = '0; in_tag = '0;
    w_in_valid = 1'b0; w_in_mode = '0; w_in_operand = '0; w_in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // back-to-back stream, latency checked
    send(0, 3'd0, 64'h00F00000, 5'd1, 64'd8, 1);
    send(0, 3'd1, 64'hFFF00000, 5'd2, 64'd12, 1);
    send(0, 3'd2, 64'h00000100, 5'd3, 64'd8, 1);
    send(0, 3'd3, 64'h0000000F, 5'd4, 64'd4, 1);
    send(0, 3'd4, 64'hA5A5A5A5, 5'd5, 64'd16, 1);
    drain();

    // boundary operands
    send(0, 3'd0, 64'h00000000, 5'd6, 64'd32, 0);
    send(0, 3'd0, 64'hFFFFFFFF, 5'd7, 64'd0, 0);
    send(0, 3'd1, 64'h00000000, 5'd8, 64'd0, 0);
    send(0, 3'd1, 64'hFFFFFFFF, 5'd9, 64'd32, 0);
    send(0, 3'd2, 64'h00000000, 5'd10, 64'd32, 0);
    send(0, 3'd2, 64'hFFFFFFFF, 5'd11, 64'd0, 0);
    send(0, 3'd3, 64'h00000000, 5'd12, 64'd0, 0);
    send(0, 3'd3, 64'hFFFFFFFF, 5'd13, 64'd32, 0);
    send(0, 3'd4, 64'h00000000, 5'd14, 64'd0, 0);
    send(0, 3'd4, 64'hFFFFFFFF, 5'd15, 64'd32, 0);
    send(0, 3'd0, 64'h80000000, 5'd16, 64'd0, 0);
    send(0, 3'd2, 64'h00000001, 5'd17, 64'd0, 0);
    send(0, 3'd6, 64'h12345678, 5'h1F, 64'd0, 0);
    send(0, 3'd5, 64'h0000FFFF, 5'd18, 64'd0, 0);
    send(0, 3'd7, 64'hFFFFFFFF, 5'd19, 64'd0, 0);
    drain();

    // backpressure: two ops fill s1/s2, third is refused until release
    out_ready = 1'b0;
    send(0, 3'd0, 64'h00010000, 5'd10, 64'd15, 0);
    send(0, 3'd2, 64'h00010000, 5'd11, 64'd16, 0);
    in_valid = 1'b1; in_mode = 3'd4; in_operand = 32'h0000FFFF; in_tag = 5'd12;
    @(negedge clk);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    idle(3);
    out_ready = 1'b1;
    send(0, 3'd4, 64'h0000FFFF, 5'd12, 64'd16, 0);
    drain();

    // flush with two ops in flight and a request in the same cycle
    out_ready = 1'b0;
    send(0, 3'd0, 64'h00000001, 5'd21, 64'd31, 0);
    send(0, 3'd4, 64'h00000007, 5'd22, 64'd3, 0);
    in_valid = 1'b1; in_mode = 3'd0; in_operand = 32'h0000FFFF; in_tag = 5'd23;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q32.delete();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    idle(4);
    in_valid = 1'b1; in_mode = 3'd1; in_operand = 32'hFFFFFFFF; in_tag = 5'd24;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_empty_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    idle(4);
    chk("flush_idle_out_valid", {63'd0, out_valid}, 64'd0);
    send(0, 3'd1, 64'hFF000000, 5'd20, 64'd8, 0);
    drain();

    // reset pulse mid-stream
    send(0, 3'd0, 64'h00000F00, 5'd25, 64'd20, 0);
    send(0, 3'd4, 64'h000000FF, 5'd26, 64'd8, 0);
    rst = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    q32.delete();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_result", 64'(out_result), 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1; out_ready = 1'b1;
    idle(4);
    chk("midrst_idle_out_valid", {63'd0, out_valid}, 64'd0);

    // 64-bit instance with 16-bit groups
    send(1, 3'd0, 64'h0, 5'd1, 64'd64, 0);
    send(1, 3'd2, 64'h0000010000000000, 5'd2, 64'd40, 0);
    send(1, 3'd0, 64'h0000010000000000, 5'd3, 64'd23, 0);
    send(1, 3'd4, 64'hFFFFFFFFFFFFFFFF, 5'd4, 64'd64, 0);
    send(1, 3'd3, 64'h00000000000000FF, 5'd5, 64'd8, 0);
    send(1, 3'd1, 64'hFFFF000000000000, 5'd6, 64'd16, 0);
    send(1, 3'd2, 64'h0, 5'd7, 64'd64, 0);
    send(1, 3'd6, 64'h123456789ABCDEF0, 5'h1F, 64'd0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
